// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: branch codes, FSM states and taken-branch helper shared by fetch and control decode
package fetch_unit_pkg;
  localparam int PC_W = 7;
  typedef enum logic [1:0] {brNext = 2'b00, brReturn = 2'b01, brDecNZ = 2'b10, brNeg = 2'b11} br_type_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_e;
  function automatic logic is_taken(input br_type_e t, input logic flag);
    return (t == brReturn) || (t == brDecNZ && !flag) || (t == brNeg && flag);
  endfunction
endpackage

// File: rtl/fetch_unit_branch_target.sv
// branch_target: combinational next-PC selection, all arithmetic modulo 128
module branch_target
  import fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0] PC,
  input  br_type_e        branchType,
  input  logic [2:0]      threewireOffset,
  input  logic [5:0]      sixwireOffset,
  input  logic            flag,
  input  logic [PC_W-1:0] returnAddr,
  output logic [PC_W-1:0] nextPC
);
  always_comb
    nextPC = !is_taken(branchType, flag) ? PC + 7'd1 :
             branchType == brReturn     ? returnAddr :
             branchType == brDecNZ      ? PC - {4'b0, threewireOffset} :
                                          PC + {sixwireOffset[5], sixwireOffset};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/RUN/HALTED sequencer owning the program counter.
// FETCH_PERF_COUNT_EN adds saturating cycleCount/takenCount outputs.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] startAddr,
  input  logic            stall,
  input  logic            halt,
  input  logic [1:0]      branchType,
  input  logic [2:0]      threewireOffset,
  input  logic [5:0]      sixwireOffset,
  input  logic            flag,
  input  logic [PC_W-1:0] returnAddr,
  output logic [PC_W-1:0] programCounter,
`ifdef FETCH_PERF_COUNT_EN
  output logic [15:0]     cycleCount,
  output logic [15:0]     takenCount,
`endif
  output logic            running,
  output logic            done
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc;
  logic            running_q, running_d, done_q, done_d;
  br_type_e        br;
  assign br = br_type_e'(branchType);
  branch_target u_bt (
    .PC(pc_q), .branchType(br), .threewireOffset(threewireOffset),
    .sixwireOffset(sixwireOffset), .flag(flag), .returnAddr(returnAddr), .nextPC(next_pc)
  );
  // stall freezes everything, halt beats any branch, start only honoured outside RUN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!stall) begin
      if (state_q == RUN) begin
        state_d = halt ? HALTED : RUN;
        pc_d    = halt ? pc_q : next_pc;
      end else if (start) begin
        state_d = RUN;
        pc_d    = startAddr;
      end
    end
    running_d = state_d == RUN;
    done_d    = state_d == HALTED;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end
  assign programCounter = pc_q;
  assign running        = running_q;
  assign done           = done_q;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] cycle_q, cycle_d, taken_q, taken_d;
  logic        step, clr;
  always_comb begin
    step    = !stall && state_q == RUN;
    clr     = !stall && state_q != RUN && start;
    cycle_d = clr ? '0 : (step && cycle_q != 16'hFFFF) ? cycle_q + 16'd1 : cycle_q;
    taken_d = clr ? '0 : (step && !halt && is_taken(br, flag) && taken_q != 16'hFFFF) ? taken_q + 16'd1 : taken_q;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      cycle_q <= '0;
      taken_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      taken_q <= taken_d;
    end
  end
  assign cycleCount = cycle_q;
  assign takenCount = taken_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with a queue scoreboard checked by an independent monitor
module tb_fetch_unit;
  logic       CLK = 0, reset = 0, start = 0, stall = 0, halt = 0, flag = 0;
  logic [6:0] startAddr = 0, returnAddr = 0, programCounter;
  logic [1:0] branchType = 0;
  logic [2:0] threewireOffset = 0;
  logic [5:0] sixwireOffset = 0;
  logic       running, done;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] cycleCount, takenCount;
`endif
  int checks = 0, errors = 0;

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .startAddr(startAddr), .stall(stall), .halt(halt),
    .branchType(branchType), .threewireOffset(threewireOffset), .sixwireOffset(sixwireOffset),
    .flag(flag), .returnAddr(returnAddr), .programCounter(programCounter),
`ifdef FETCH_PERF_COUNT_EN
    .cycleCount(cycleCount), .takenCount(takenCount),
`endif
    .running(running), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [6:0] pc;
    logic       run;
    logic       dn;
    logic       cnt0;
  } exp_t;
  exp_t sb[$];

  task automatic go(input string nm, input logic [6:0] pc, input logic run, input logic dn, input logic cnt0 = 0);
    exp_t e;
    @(posedge CLK);
    e.name = nm; e.pc = pc; e.run = run; e.dn = dn; e.cnt0 = cnt0;
    sb.push_back(e);
    #1;
    reset = 0; start = 0; stall = 0; halt = 0; flag = 0;
    branchType = 2'b00; threewireOffset = 0; sixwireOffset = 0;
  endtask

  task automatic jump(input logic [6:0] a);
    @(negedge CLK); branchType = 2'b01; returnAddr = a; go("setup_ret", a, 1, 0);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (programCounter !== e.pc || running !== e.run || done !== e.dn) begin
        errors++;
        $display("FAIL %s: got pc=%0d running=%b done=%b, want pc=%0d running=%b done=%b",
                 e.name, programCounter, running, done, e.pc, e.run, e.dn);
      end
`ifdef FETCH_PERF_COUNT_EN
      if (e.cnt0) begin
        checks++;
        if (cycleCount !== 16'd0 || takenCount !== 16'd0) begin
          errors++;
          $display("FAIL %s_counters: got cycle=%0d taken=%0d, want 0 0", e.name, cycleCount, takenCount);
        end
      end
`endif
    end
  end

  initial begin
    @(negedge CLK); reset = 1; go("reset", 0, 0, 0, 1);
    @(negedge CLK); branchType = 2'b00; go("idle_no_start", 0, 0, 0, 1);
    @(negedge CLK); start = 1; startAddr = 10; go("start10", 10, 1, 0);
    @(negedge CLK); go("seq11", 11, 1, 0);
    @(negedge CLK); go("seq12", 12, 1, 0);
    @(negedge CLK); start = 1; startAddr = 99; go("start_ignored", 13, 1, 0);
    jump(20);
    @(negedge CLK); branchType = 2'b10; threewireOffset = 4; flag = 0; go("decnz_taken", 16, 1, 0);
    jump(20);
    @(negedge CLK); branchType = 2'b10; threewireOffset = 4; flag = 1; go("decnz_fall", 21, 1, 0);
    @(negedge CLK); branchType = 2'b10; threewireOffset = 0; flag = 0; go("decnz_off0", 21, 1, 0);
    jump(5);
    @(negedge CLK); branchType = 2'b11; sixwireOffset = 6'b111000; flag = 1; go("neg_wrap", 125, 1, 0);
    @(negedge CLK); branchType = 2'b11; sixwireOffset = 6'b000011; flag = 0; go("neg_fall", 126, 1, 0);
    @(negedge CLK); branchType = 2'b11; sixwireOffset = 6'b000011; flag = 1; go("neg_fwd_wrap", 1, 1, 0);
    jump(127);
    @(negedge CLK); go("inc_wrap", 0, 1, 0);
    jump(40);
    @(negedge CLK); branchType = 2'b01; returnAddr = 7; stall = 1; go("stall_ret", 40, 1, 0);
    @(negedge CLK); branchType = 2'b01; returnAddr = 7; go("ret", 7, 1, 0);
    jump(30);
    @(negedge CLK); halt = 1; stall = 1; go("stall_over_halt", 30, 1, 0);
    @(negedge CLK); halt = 1; branchType = 2'b11; sixwireOffset = 6'b000101; flag = 1; go("halt_over_br", 30, 0, 1);
    @(negedge CLK); branchType = 2'b01; returnAddr = 3; go("halted_hold", 30, 0, 1);
    @(negedge CLK); start = 1; startAddr = 0; go("restart0", 0, 1, 0);
    jump(50);
    @(negedge CLK); reset = 1; start = 1; startAddr = 9; go("reset_midrun", 0, 0, 0, 1);
    @(negedge CLK); go("idle_after_reset", 0, 0, 0, 1);
    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
